// File: rtl/logic_op_pipe.sv
// Bitwise AND/OR/XOR/XNOR on two operands; build with LOGIC_OP_PIPE_ACC_EN to make op=3 an OR-accumulate with acc_clr.
// Latency: LATENCY cycles from accept to out_valid, one result per cycle when out_ready stays high.
// Backpressure: the stage chain stalls from the tail, empty stages still fill, and in_ready falls only when every stage is full.
module logic_op_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_OP_PIPE_ACC_EN
  input  logic             acc_clr,
`endif
  output logic [WIDTH-1:0] out
);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] adv;
  logic [WIDTH-1:0]   data_q [LATENCY];
  logic               accept;
  logic [WIDTH-1:0]   res;

  // A stage may advance unless it and every stage after it are full with the tail stalled.
  for (genvar g = 0; g < LATENCY; g++) begin : g_adv
    assign adv[g] = out_ready | ~(&vld_q[LATENCY-1:g]);
  end

  assign in_ready = adv[0];
  assign accept   = in_valid & in_ready;

`ifdef LOGIC_OP_PIPE_ACC_EN
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_nxt;

  assign acc_nxt = (acc_clr ? '0 : acc_q) | (in1 & in2);

  always_comb begin
    acc_d = acc_q;
    if (accept && (op == 2'd3)) begin
      acc_d = acc_nxt;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  always_comb begin
    res = '0;
    case (op)
      2'd0:    res = in1 & in2;
      2'd1:    res = in1 | in2;
      2'd2:    res = in1 ^ in2;
`ifdef LOGIC_OP_PIPE_ACC_EN
      default: res = acc_nxt;
`else
      default: res = ~(in1 ^ in2);
`endif
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        vld_q[0] <= accept;
        if (accept) begin
          data_q[0] <= res;
        end
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (adv[i]) begin
          vld_q[i]  <= vld_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out       = data_q[LATENCY-1];

endmodule

// File: tb/tb_logic_op_pipe.sv
// Bench for logic_op_pipe (WIDTH=8, LATENCY=2): vector table plus stall, bubble, reset and accumulator sequences.
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       out_valid;
  logic       out_ready;
  logic       acc_clr;
  logic [7:0] out;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [12];
  vec_t stl [4];

  logic_op_pipe #(.WIDTH(8), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_OP_PIPE_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every result handed downstream must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {56'd0, out}, 64'hdead);
      end else begin
        check("out", {56'd0, out}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input bit chk_rdy);
    bit got = 0;
    in_valid = 1'b1;
    op = o;
    in1 = a;
    in2 = b;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (chk_rdy) check("in_ready_stream", in_ready, 1);
      if (in_ready) begin
        exp_q.push_back(exp);
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    tbl[0]  = '{2'd0, 8'hA5, 8'h0F, 8'h05};
    tbl[1]  = '{2'd1, 8'hA5, 8'h0F, 8'hAF};
    tbl[2]  = '{2'd2, 8'hA5, 8'h0F, 8'hAA};
    tbl[3]  = '{2'd3, 8'hF0, 8'h3C, 8'h33};
    tbl[4]  = '{2'd1, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{2'd2, 8'hFF, 8'hFF, 8'h00};
    tbl[6]  = '{2'd0, 8'hFF, 8'hFF, 8'hFF};
    tbl[7]  = '{2'd3, 8'h55, 8'hAA, 8'h00};
    tbl[8]  = '{2'd1, 8'h12, 8'h34, 8'h36};
    tbl[9]  = '{2'd2, 8'h12, 8'h34, 8'h26};
    tbl[10] = '{2'd3, 8'h12, 8'h34, 8'hD9};
    tbl[11] = '{2'd0, 8'h3C, 8'hC3, 8'h00};
    stl[0]  = '{2'd0, 8'hC3, 8'h0F, 8'h03};
    stl[1]  = '{2'd1, 8'hC3, 8'h0F, 8'hCF};
    stl[2]  = '{2'd2, 8'hC3, 8'h0F, 8'hCC};
    stl[3]  = '{2'd0, 8'hFF, 8'h81, 8'h81};

    rst = 1'b1; in_valid = 1'b0; op = 2'd0; in1 = 8'h00; in2 = 8'h00;
    out_ready = 1'b1; acc_clr = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // First transaction latency: accept at edge 0, valid after edge 1.
    send(2'd0, 8'hF0, 8'h3C, 8'h30, 0);
    check("lat_valid_early", out_valid, 0);
    check("lat_out_early", out, 0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    check("lat_out", out, 8'h30);
    drain();

    // Back-to-back table stream at full throughput.
    for (int i = 0; i < 12; i++) begin
`ifdef LOGIC_OP_PIPE_ACC_EN
      if (tbl[i].op == 2'd3) continue;
`endif
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1);
    end
    drain();

    // Stall: four transactions offered with out_ready low.
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1; op = stl[0].op; in1 = stl[0].a; in2 = stl[0].b;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_out_hold", out, 8'h03);
      end
      if (in_ready && k < 4) begin
        exp_q.push_back(stl[k].exp);
        k++;
      end
      @(posedge clk); #1;
      if (k < 4) begin
        op = stl[k].op; in1 = stl[k].a; in2 = stl[k].b;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stall_accepts", k, 2);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(stl[k].exp);
        k++;
      end
      @(posedge clk); #1;
      if (k < 4) begin
        op = stl[k].op; in1 = stl[k].a; in2 = stl[k].b;
      end
    end
    in_valid = 1'b0;
    check("stall_all_accepted", k, 4);
    drain();

    // Bubble: stalled tail with an empty stage 0 must still accept.
    out_ready = 1'b0;
    send(2'd1, 8'h10, 8'h01, 8'h11, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bubble_in_ready", in_ready, 1);
    check("bubble_out_valid", out_valid, 1);
    @(posedge clk); #1;
    send(2'd2, 8'h10, 8'h03, 8'h13, 0);
    @(negedge clk);
    check("bubble_full", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset with two results in flight.
    send(2'd0, 8'hFF, 8'h0F, 8'h0F, 0);
    send(2'd1, 8'hF0, 8'h0F, 8'hFF, 0);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

`ifdef LOGIC_OP_PIPE_ACC_EN
    send(2'd3, 8'h01, 8'hFF, 8'h01, 0);
    send(2'd3, 8'h80, 8'hFF, 8'h81, 0);
    acc_clr = 1'b1;
    send(2'd3, 8'h02, 8'h02, 8'h02, 0);
    acc_clr = 1'b0;
    drain();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(2'd3, 8'h04, 8'h04, 8'h04, 0);
    send(2'd0, 8'hFF, 8'h00, 8'h00, 0);
    send(2'd3, 8'h00, 8'h00, 8'h04, 0);
    drain();
`else
    send(2'd3, 8'hF0, 8'h3C, 8'h33, 0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
